// File: rtl/bus_slave_mux_tmo_if.sv
// Bus bundle between the slave channels and the shared master return path.
//
// Handshake: an access to slave i is live while s_cs_[i] is low; the slave
// completes it by pulling s_rdy_[i] low with valid data on its s_rd_data
// slice in the same cycle. The return path has no backpressure: m_rdy_ is
// a single-cycle low pulse, and m_rd_data/m_err are meaningful only in
// that cycle. m_err high with m_rdy_ low marks a watchdog timeout.
interface bus_slave_mux_tmo_if #(
  parameter int SLAVE_NUM = 8,
  parameter int DATA_W    = 32
);
  logic [SLAVE_NUM-1:0]        s_cs_;
  logic [SLAVE_NUM*DATA_W-1:0] s_rd_data;
  logic [SLAVE_NUM-1:0]        s_rdy_;
  logic                        err_clr;
  logic [DATA_W-1:0]           m_rd_data;
  logic                        m_rdy_;
  logic                        m_err;
  logic                        multi_cs_err;

  // The mux itself sits on this side.
  modport slave (
    input  s_cs_, s_rd_data, s_rdy_, err_clr,
    output m_rd_data, m_rdy_, m_err, multi_cs_err
  );

  // Environment side: drives the slave channels, observes the return path.
  modport master (
    output s_cs_, s_rd_data, s_rdy_, err_clr,
    input  m_rd_data, m_rdy_, m_err, multi_cs_err
  );
endinterface

// File: rtl/bus_slave_mux_tmo.sv
// Registered read-return mux: picks the lowest-index slave with chip select
// asserted, holds that choice for the whole access, forwards its data and
// ready through one register stage, and answers with an error response if
// the slave never becomes ready within TIMEOUT wait cycles.
module bus_slave_mux_tmo #(
  parameter int SLAVE_NUM = 8,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  bus_slave_mux_tmo_if.slave      bus,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int SEL_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  // Counter value in the last wait cycle before the timeout response.
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t               state;
  logic [SEL_W-1:0]     sel;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    rd_data_q;
  logic                 rdy_q;
  logic                 err_q;
  logic                 multi_q;

  logic                 hit;
  logic [SEL_W-1:0]     idx;
  logic [SLAVE_NUM-1:0] cs_low;
  logic                 multi;
  logic                 sel_cs;
  logic                 sel_rdy;
  logic [DATA_W-1:0]    sel_data;

  // Priority encoder: scanning downward lets the lowest active index win.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (!bus.s_cs_[i]) begin
        hit = 1'b1;
        idx = SEL_W'(i);
      end
    end
  end

  // Two or more selects low: clearing the lowest set bit leaves something.
  assign cs_low   = ~bus.s_cs_;
  assign multi    = |(cs_low & (cs_low - SLAVE_NUM'(1)));

  assign sel_cs   = bus.s_cs_[sel];
  assign sel_rdy  = bus.s_rdy_[sel];
  assign sel_data = bus.s_rd_data[sel*DATA_W +: DATA_W];

  // Access FSM with registered return-path outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel       <= '0;
      cnt       <= '0;
      rd_data_q <= '0;
      rdy_q     <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            sel   <= idx;
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_cs) begin
            // Master withdrew the access: no response.
            state <= ST_IDLE;
          end else if (!sel_rdy) begin
            // Ready is checked before the watchdog so it wins a tie.
            rd_data_q <= sel_data;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            state     <= ST_RESP;
          end else if (TMO_EN && (cnt == CNT_LAST)) begin
            rd_data_q <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b1;
            state     <= ST_RESP;
          end else if (cnt != '1) begin
            // Saturate so a disabled watchdog never wraps.
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          rd_data_q <= '0;
          rdy_q     <= 1'b1;
          err_q     <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky multi-select flag; a new violation beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      multi_q <= 1'b0;
    end else if (multi) begin
      multi_q <= 1'b1;
    end else if (bus.err_clr) begin
      multi_q <= 1'b0;
    end
  end

  assign bus.m_rd_data    = rd_data_q;
  assign bus.m_rdy_       = rdy_q;
  assign bus.m_err        = err_q;
  assign bus.multi_cs_err = multi_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_bus_slave_mux_tmo.sv
// Directed bench for bus_slave_mux_tmo: a vector table for the single-cycle
// select/response/flag behaviour, plus hand-written sequences for the
// watchdog, abort, reset and disabled-watchdog cases.
module tb_bus_slave_mux_tmo;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state0;

  int n_vec = 0;
  int n_bad = 0;

  bus_slave_mux_tmo_if #(.SLAVE_NUM(8), .DATA_W(32)) bus  ();
  bus_slave_mux_tmo_if #(.SLAVE_NUM(8), .DATA_W(32)) bus0 ();

  bus_slave_mux_tmo #(.SLAVE_NUM(8), .DATA_W(32), .TIMEOUT(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  bus_slave_mux_tmo #(.SLAVE_NUM(8), .DATA_W(32), .TIMEOUT(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .dbg_state (dbg_state0)
  );

  // Clock and run-time bound.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within 100000 ns");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    string       name;
    logic [7:0]  cs;
    logic [7:0]  rdy;
    logic        clr;
    logic        exp_rdy;
    logic        exp_err;
    logic [31:0] exp_data;
    logic        exp_mcs;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[15];

  // Driver tasks.
  task automatic drive(input logic [7:0] cs, input logic [7:0] rdy, input logic clr);
    bus.s_cs_   = cs;
    bus.s_rdy_  = rdy;
    bus.err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard compare against the main instance.
  task automatic check(input string name, input logic er, input logic ee,
                       input logic [31:0] ed, input logic em, input logic [1:0] es);
    n_vec++;
    if (bus.m_rdy_ !== er || bus.m_err !== ee || bus.m_rd_data !== ed ||
        bus.multi_cs_err !== em || dbg_state !== es) begin
      n_bad++;
      $display("FAIL %s: got rdy_=%b err=%b data=%h mcs=%b state=%0d, expected rdy_=%b err=%b data=%h mcs=%b state=%0d",
               name, bus.m_rdy_, bus.m_err, bus.m_rd_data, bus.multi_cs_err, dbg_state,
               er, ee, ed, em, es);
    end
  endtask

  initial begin
    logic seen;

    // Slave i always presents CAFE000i on its data slice.
    for (int i = 0; i < 8; i++) begin
      bus.s_rd_data[i*32 +: 32]  = 32'hCAFE0000 + 32'(i);
      bus0.s_rd_data[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
    end
    drive(8'hFF, 8'hFF, 1'b0);
    bus0.s_cs_   = 8'hFF;
    bus0.s_rdy_  = 8'hFF;
    bus0.err_clr = 1'b0;

    // Reset block.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", 1'b1, 1'b0, 32'h0, 1'b0, S_IDLE);
    reset = 1'b0;

    //            name          cs     rdy    clr   rdy_  err   data          mcs   state
    vecs[0]  = '{"t1_cs",      8'hF7, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, S_WAIT};
    vecs[1]  = '{"t1_wait",    8'hF7, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, S_WAIT};
    vecs[2]  = '{"t1_resp",    8'hF7, 8'hF7, 1'b0, 1'b0, 1'b0, 32'hCAFE0003, 1'b0, S_RESP};
    vecs[3]  = '{"t1_idle",    8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, S_IDLE};
    vecs[4]  = '{"t3_multi",   8'hF5, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, S_WAIT};
    vecs[5]  = '{"t3_resp",    8'hF5, 8'hFD, 1'b0, 1'b0, 1'b0, 32'hCAFE0001, 1'b1, S_RESP};
    vecs[6]  = '{"t3_sticky",  8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, S_IDLE};
    vecs[7]  = '{"t3_setwins", 8'hF5, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, S_WAIT};
    vecs[8]  = '{"t3_clear",   8'hFD, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, S_WAIT};
    vecs[9]  = '{"b2b_resp",   8'hFD, 8'hFD, 1'b0, 1'b0, 1'b0, 32'hCAFE0001, 1'b0, S_RESP};
    vecs[10] = '{"b2b_idle",   8'hFD, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, S_IDLE};
    vecs[11] = '{"b2b_rewait", 8'hFD, 8'hFF, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, S_WAIT};
    vecs[12] = '{"nopreempt",  8'hFC, 8'hFE, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, S_WAIT};
    vecs[13] = '{"np_resp",    8'hFC, 8'hFD, 1'b0, 1'b0, 1'b0, 32'hCAFE0001, 1'b1, S_RESP};
    vecs[14] = '{"np_clear",   8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, S_IDLE};

    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].cs, vecs[v].rdy, vecs[v].clr);
      tick();
      check(vecs[v].name, vecs[v].exp_rdy, vecs[v].exp_err, vecs[v].exp_data,
            vecs[v].exp_mcs, vecs[v].exp_state);
    end
    drive(8'hFF, 8'hFF, 1'b0);

    // Watchdog on slave 5: 16 wait cycles, error response on the 17th.
    drive(8'hDF, 8'hFF, 1'b0);
    tick();
    check("tmo_enter", 1'b1, 1'b0, 32'h0, 1'b0, S_WAIT);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("tmo_wait%0d", k), 1'b1, 1'b0, 32'h0, 1'b0, S_WAIT);
    end
    tick();
    check("tmo_resp", 1'b0, 1'b1, 32'h0, 1'b0, S_RESP);
    drive(8'hFF, 8'hFF, 1'b0);
    tick();
    check("tmo_idle", 1'b1, 1'b0, 32'h0, 1'b0, S_IDLE);

    // Slave 0 ready in exactly the timeout cycle: ready wins.
    drive(8'hFE, 8'hFF, 1'b0);
    tick();
    check("tie_enter", 1'b1, 1'b0, 32'h0, 1'b0, S_WAIT);
    for (int k = 1; k <= 15; k++) tick();
    check("tie_wait15", 1'b1, 1'b0, 32'h0, 1'b0, S_WAIT);
    drive(8'hFE, 8'hFE, 1'b0);
    tick();
    check("tie_resp", 1'b0, 1'b0, 32'hCAFE0000, 1'b0, S_RESP);
    drive(8'hFF, 8'hFF, 1'b0);
    tick();
    check("tie_idle", 1'b1, 1'b0, 32'h0, 1'b0, S_IDLE);

    // Slave 2 aborted after 4 wait cycles, then slave 6 right away.
    drive(8'hFB, 8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("abort_wait", 1'b1, 1'b0, 32'h0, 1'b0, S_WAIT);
    drive(8'hBF, 8'hFF, 1'b0);
    tick();
    check("abort_idle", 1'b1, 1'b0, 32'h0, 1'b0, S_IDLE);
    tick();
    check("s6_wait", 1'b1, 1'b0, 32'h0, 1'b0, S_WAIT);
    drive(8'hBF, 8'hBF, 1'b0);
    tick();
    check("s6_resp", 1'b0, 1'b0, 32'hCAFE0006, 1'b0, S_RESP);
    drive(8'hFF, 8'hFF, 1'b0);
    tick();
    check("s6_idle", 1'b1, 1'b0, 32'h0, 1'b0, S_IDLE);

    // Slave 4 (with slave 6 also selected) reset while the response is up.
    drive(8'hAF, 8'hFF, 1'b0);
    tick();
    check("rst_wait", 1'b1, 1'b0, 32'h0, 1'b1, S_WAIT);
    drive(8'hAF, 8'hEF, 1'b0);
    tick();
    check("rst_resp", 1'b0, 1'b0, 32'hCAFE0004, 1'b1, S_RESP);
    reset = 1'b1;
    #1;
    check("rst_async", 1'b1, 1'b0, 32'h0, 1'b0, S_IDLE);
    drive(8'hFF, 8'hFF, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_after", 1'b1, 1'b0, 32'h0, 1'b0, S_IDLE);

    // Disabled watchdog: slave 4 never ready, no response ever.
    bus0.s_cs_  = 8'hEF;
    bus0.s_rdy_ = 8'hFF;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus0.m_rdy_ !== 1'b1 || bus0.m_err !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || dbg_state0 !== S_WAIT || bus0.m_rd_data !== 32'h0) begin
      n_bad++;
      $display("FAIL tmo0_none: got response_seen=%b state=%0d data=%h, expected response_seen=0 state=%0d data=00000000",
               seen, dbg_state0, bus0.m_rd_data, S_WAIT);
    end
    bus0.s_cs_ = 8'hFF;
    tick();
    n_vec++;
    if (dbg_state0 !== S_IDLE || bus0.m_rdy_ !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo0_abort: got state=%0d rdy_=%b, expected state=%0d rdy_=1",
               dbg_state0, bus0.m_rdy_, S_IDLE);
    end

    // Final report.
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
